// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller for the D/E/M/W CPU.
// Decodes the D-stage instruction into source registers with their Tuse, a
// destination register and its Tnew. A private E/M/W shadow pipeline of these
// entries produces the freeze/bubble request and the bypass selects. A
// mult/div busy counter holds off md instructions while the unit is working.
//
// Ports:
//   clk        rising-edge clock
//   reset      asynchronous, active-low reset
//   instr_d    D-stage instruction (held upstream while stall=1)
//   stall      freeze PC and F/D, bubble into E
//   fwd_rs_d   D rs bypass   : 0 GRF, 1 from E, 2 from M
//   fwd_rt_d   D rt bypass   : same encoding
//   fwd_rs_e   E rs bypass   : 0 pipeline reg, 1 from M, 2 from W
//   fwd_rt_e   E rt bypass   : same encoding
//   fwd_rt_m   M rt (sw data) bypass from W
//   md_busy    mult/div unit busy
//   md_start   mult/div in E (start pulse to the unit)

package hazard_ctrl_pkg;
   localparam logic [1:0] MD_NONE = 2'd0;
   localparam logic [1:0] MD_MUL  = 2'd1;
   localparam logic [1:0] MD_DIV  = 2'd2;

   // Shadow-pipeline entry; rs/rt are zero when the instruction does not read them.
   typedef struct packed {
      logic [4:0] dst;
      logic [1:0] tnew;
      logic [4:0] rs;
      logic [4:0] rt;
      logic [1:0] md;
   } stage_t;
endpackage

module hazard_ctrl
   import hazard_ctrl_pkg::*;
#(
   parameter int unsigned MUL_CYC = 5,
   parameter int unsigned DIV_CYC = 10,
   parameter int unsigned CNT_W   = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] instr_d,
   output logic        stall,
   output logic [1:0]  fwd_rs_d,
   output logic [1:0]  fwd_rt_d,
   output logic [1:0]  fwd_rs_e,
   output logic [1:0]  fwd_rt_e,
   output logic        fwd_rt_m,
   output logic        md_busy,
   output logic        md_start
);

   localparam logic [5:0] OP_RTYPE = 6'h00;
   localparam logic [5:0] OP_JAL   = 6'h03;
   localparam logic [5:0] OP_BEQ   = 6'h04;
   localparam logic [5:0] OP_ORI   = 6'h0d;
   localparam logic [5:0] OP_LUI   = 6'h0f;
   localparam logic [5:0] OP_LW    = 6'h23;
   localparam logic [5:0] OP_SW    = 6'h2b;

   localparam logic [5:0] F_SLL    = 6'h00;
   localparam logic [5:0] F_JR     = 6'h08;
   localparam logic [5:0] F_JALR   = 6'h09;
   localparam logic [5:0] F_MFHI   = 6'h10;
   localparam logic [5:0] F_MFLO   = 6'h12;
   localparam logic [5:0] F_MULT   = 6'h18;
   localparam logic [5:0] F_DIV    = 6'h1a;
   localparam logic [5:0] F_ADDU   = 6'h21;
   localparam logic [5:0] F_SUBU   = 6'h23;

   logic [5:0]       opcode;
   logic [5:0]       funct;
   logic [4:0]       f_rs;
   logic [4:0]       f_rt;
   logic [4:0]       f_rd;

   stage_t           d_ent;
   logic [1:0]       d_tuse_rs;
   logic [1:0]       d_tuse_rt;
   logic             d_md_op;

   stage_t           e_q;
   stage_t           m_q;
   stage_t           w_q;
   stage_t           m_next;
   logic [CNT_W-1:0] cnt_q;

   logic             data_stall;
   logic             md_stall;
   logic             unused_bits;

   assign opcode = instr_d[31:26];
   assign f_rs   = instr_d[25:21];
   assign f_rt   = instr_d[20:16];
   assign f_rd   = instr_d[15:11];
   assign funct  = instr_d[5:0];

   // Shamt and the W-stage payload beyond dst are carried but never inspected.
   assign unused_bits = ^{instr_d[10:6], w_q.tnew, w_q.rs, w_q.rt, w_q.md};

   // Source r with use time t collides with a producer in E or M whose result is later.
   function automatic logic src_hazard(input logic [4:0] r, input logic [1:0] t,
                                       input stage_t e, input stage_t m);
      return (r != 5'd0) &&
             (((e.dst == r) && (e.tnew > t)) || ((m.dst == r) && (m.tnew > t)));
   endfunction

   // D-stage bypass: nearest ready producer wins (E over M).
   function automatic logic [1:0] sel_d(input logic [4:0] r, input stage_t e, input stage_t m);
      if (r == 5'd0)                              return 2'd0;
      else if ((e.dst == r) && (e.tnew == 2'd0))  return 2'd1;
      else if ((m.dst == r) && (m.tnew == 2'd0))  return 2'd2;
      else                                        return 2'd0;
   endfunction

   // E-stage bypass: ready M result first, then whatever W is writing.
   function automatic logic [1:0] sel_e(input logic [4:0] r, input stage_t m, input stage_t w);
      if (r == 5'd0)                              return 2'd0;
      else if ((m.dst == r) && (m.tnew == 2'd0))  return 2'd1;
      else if (w.dst == r)                        return 2'd2;
      else                                        return 2'd0;
   endfunction

   // Instruction decode into sources/Tuse and destination/Tnew.
   always_comb begin
      d_ent     = '0;
      d_tuse_rs = 2'd0;
      d_tuse_rt = 2'd0;
      d_md_op   = 1'b0;
      case (opcode)
         OP_RTYPE: begin
            case (funct)
               F_ADDU, F_SUBU: begin
                  d_ent.rs   = f_rs;
                  d_ent.rt   = f_rt;
                  d_tuse_rs  = 2'd1;
                  d_tuse_rt  = 2'd1;
                  d_ent.dst  = f_rd;
                  d_ent.tnew = 2'd1;
               end
               F_SLL: begin
                  d_ent.rt   = f_rt;
                  d_tuse_rt  = 2'd1;
                  d_ent.dst  = f_rd;
                  d_ent.tnew = 2'd1;
               end
               F_JR: begin
                  d_ent.rs   = f_rs;
                  d_tuse_rs  = 2'd0;
               end
               F_JALR: begin
                  d_ent.rs   = f_rs;
                  d_tuse_rs  = 2'd0;
                  d_ent.dst  = f_rd;
                  d_ent.tnew = 2'd0;
               end
               F_MULT, F_DIV: begin
                  d_ent.rs   = f_rs;
                  d_ent.rt   = f_rt;
                  d_tuse_rs  = 2'd1;
                  d_tuse_rt  = 2'd1;
                  d_ent.md   = (funct == F_DIV) ? MD_DIV : MD_MUL;
                  d_md_op    = 1'b1;
               end
               F_MFHI, F_MFLO: begin
                  d_ent.dst  = f_rd;
                  d_ent.tnew = 2'd1;
                  d_md_op    = 1'b1;
               end
               default: ;
            endcase
         end
         OP_ORI: begin
            d_ent.rs   = f_rs;
            d_tuse_rs  = 2'd1;
            d_ent.dst  = f_rt;
            d_ent.tnew = 2'd1;
         end
         OP_LUI: begin
            d_ent.dst  = f_rt;
            d_ent.tnew = 2'd1;
         end
         OP_LW: begin
            d_ent.rs   = f_rs;
            d_tuse_rs  = 2'd1;
            d_ent.dst  = f_rt;
            d_ent.tnew = 2'd2;
         end
         OP_SW: begin
            d_ent.rs   = f_rs;
            d_ent.rt   = f_rt;
            d_tuse_rs  = 2'd1;
            d_tuse_rt  = 2'd2;
         end
         OP_BEQ: begin
            d_ent.rs   = f_rs;
            d_ent.rt   = f_rt;
            d_tuse_rs  = 2'd0;
            d_tuse_rt  = 2'd0;
         end
         OP_JAL: begin
            d_ent.dst  = 5'd31;
            d_ent.tnew = 2'd0;
         end
         default: ;
      endcase
   end

   assign md_start = (e_q.md != MD_NONE);
   assign md_busy  = (cnt_q != '0);

   // Stall request: data hazards on either source, or md op while the unit is occupied.
   always_comb begin
      data_stall = src_hazard(d_ent.rs, d_tuse_rs, e_q, m_q) |
                   src_hazard(d_ent.rt, d_tuse_rt, e_q, m_q);
      md_stall   = d_md_op & (md_busy | md_start);
      stall      = data_stall | md_stall;
   end

   // Bypass selects for D, E and M consumers.
   always_comb begin
      fwd_rs_d = sel_d(d_ent.rs, e_q, m_q);
      fwd_rt_d = sel_d(d_ent.rt, e_q, m_q);
      fwd_rs_e = sel_e(e_q.rs, m_q, w_q);
      fwd_rt_e = sel_e(e_q.rt, m_q, w_q);
      fwd_rt_m = (m_q.rt != 5'd0) && (w_q.dst == m_q.rt);
   end

   // E entry moving to M has one cycle less to produce its result.
   always_comb begin
      m_next      = e_q;
      m_next.tnew = (e_q.tnew == 2'd0) ? 2'd0 : e_q.tnew - 2'd1;
   end

   // Shadow pipeline advance; a stall turns the E slot into a bubble.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         e_q <= '0;
         m_q <= '0;
         w_q <= '0;
      end else begin
         w_q <= m_q;
         m_q <= m_next;
         e_q <= stall ? stage_t'('0) : d_ent;
      end
   end

   // Busy counter loads when a mult/div sits in E, then counts down to idle.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cnt_q <= '0;
      end else if (md_start) begin
         cnt_q <= (e_q.md == MD_DIV) ? CNT_W'(DIV_CYC) : CNT_W'(MUL_CYC);
      end else if (cnt_q != '0) begin
         cnt_q <= cnt_q - CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed hazard scenarios plus a randomized instruction
// stream checked against an instruction-level reference model.
module tb_hazard_ctrl;

   localparam int unsigned MUL_CYC = 5;
   localparam int unsigned DIV_CYC = 10;
   localparam int unsigned CNT_W   = 4;

   logic        clk;
   logic        reset;
   logic [31:0] instr_d;
   logic        stall;
   logic [1:0]  fwd_rs_d;
   logic [1:0]  fwd_rt_d;
   logic [1:0]  fwd_rs_e;
   logic [1:0]  fwd_rt_e;
   logic        fwd_rt_m;
   logic        md_busy;
   logic        md_start;

   int total = 0;
   int bad   = 0;

   hazard_ctrl #(.MUL_CYC(MUL_CYC), .DIV_CYC(DIV_CYC), .CNT_W(CNT_W)) dut (
      .clk(clk), .reset(reset), .instr_d(instr_d), .stall(stall),
      .fwd_rs_d(fwd_rs_d), .fwd_rt_d(fwd_rt_d), .fwd_rs_e(fwd_rs_e),
      .fwd_rt_e(fwd_rt_e), .fwd_rt_m(fwd_rt_m), .md_busy(md_busy),
      .md_start(md_start)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- encoders ----------------
   function automatic logic [31:0] r_type(input logic [4:0] rs, input logic [4:0] rt,
                                          input logic [4:0] rd, input logic [5:0] fn);
      return {6'h00, rs, rt, rd, 5'd0, fn};
   endfunction

   function automatic logic [31:0] i_type(input logic [5:0] op, input logic [4:0] rs,
                                          input logic [4:0] rt, input logic [15:0] imm);
      return {op, rs, rt, imm};
   endfunction

   // ---------------- reference model ----------------
   // An issued instruction: what it writes, when (Tnew at issue), what it reads.
   typedef struct {
      int dst;
      int tnew;
      int rs;
      int rt;
      int md;     // 0 none, 1 mult, 2 div
   } inst_t;

   typedef struct {
      inst_t body;
      int    tuse_rs;
      int    tuse_rt;
      bit    md_op;
   } dec_t;

   inst_t pipe[3];      // index = stages past D: 0 E, 1 M, 2 W
   int    md_left;
   dec_t  cur;
   bit    x_stall, x_fwd_rt_m, x_md_busy, x_md_start;
   int    x_fwd_rs_d, x_fwd_rt_d, x_fwd_rs_e, x_fwd_rt_e;

   function automatic inst_t empty_inst();
      inst_t n;
      n.dst = 0; n.tnew = 0; n.rs = 0; n.rt = 0; n.md = 0;
      return n;
   endfunction

   function automatic dec_t decode(input logic [31:0] ins);
      dec_t d;
      int op, fn, rs, rt, rd;
      op = int'(ins[31:26]); fn = int'(ins[5:0]);
      rs = int'(ins[25:21]); rt = int'(ins[20:16]); rd = int'(ins[15:11]);
      d.body = empty_inst(); d.tuse_rs = 0; d.tuse_rt = 0; d.md_op = 1'b0;
      if (op == 0) begin
         case (fn)
            'h21, 'h23: begin d.body.rs = rs; d.tuse_rs = 1; d.body.rt = rt; d.tuse_rt = 1;
                              d.body.dst = rd; d.body.tnew = 1; end
            'h00:       begin d.body.rt = rt; d.tuse_rt = 1; d.body.dst = rd; d.body.tnew = 1; end
            'h08:       begin d.body.rs = rs; d.tuse_rs = 0; end
            'h09:       begin d.body.rs = rs; d.tuse_rs = 0; d.body.dst = rd; d.body.tnew = 0; end
            'h18, 'h1a: begin d.body.rs = rs; d.tuse_rs = 1; d.body.rt = rt; d.tuse_rt = 1;
                              d.body.md = (fn == 'h18) ? 1 : 2; d.md_op = 1'b1; end
            'h10, 'h12: begin d.body.dst = rd; d.body.tnew = 1; d.md_op = 1'b1; end
            default: ;
         endcase
      end else begin
         case (op)
            'h0d: begin d.body.rs = rs; d.tuse_rs = 1; d.body.dst = rt; d.body.tnew = 1; end
            'h0f: begin d.body.dst = rt; d.body.tnew = 1; end
            'h23: begin d.body.rs = rs; d.tuse_rs = 1; d.body.dst = rt; d.body.tnew = 2; end
            'h2b: begin d.body.rs = rs; d.tuse_rs = 1; d.body.rt = rt; d.tuse_rt = 2; end
            'h04: begin d.body.rs = rs; d.body.rt = rt; end
            'h03: begin d.body.dst = 31; d.body.tnew = 0; end
            default: ;
         endcase
      end
      return d;
   endfunction

   // Cycles still needed before a producer k stages past D has its result.
   function automatic int remaining(input int k);
      int r;
      r = pipe[k].tnew - k;
      return (r < 0) ? 0 : r;
   endfunction

   function automatic int model_fwd_d(input int r);
      if (r == 0) return 0;
      if (pipe[0].dst == r && remaining(0) == 0) return 1;
      if (pipe[1].dst == r && remaining(1) == 0) return 2;
      return 0;
   endfunction

   function automatic int model_fwd_e(input int r);
      if (r == 0) return 0;
      if (pipe[1].dst == r && remaining(1) == 0) return 1;
      if (pipe[2].dst == r) return 2;
      return 0;
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) pipe[k] = empty_inst();
      md_left = 0;
   endtask

   task automatic model_eval();
      cur     = decode(instr_d);
      x_stall = 1'b0;
      for (int k = 0; k < 2; k++) begin
         if (pipe[k].dst != 0) begin
            if (pipe[k].dst == cur.body.rs && remaining(k) > cur.tuse_rs) x_stall = 1'b1;
            if (pipe[k].dst == cur.body.rt && remaining(k) > cur.tuse_rt) x_stall = 1'b1;
         end
      end
      x_md_start = (pipe[0].md != 0);
      x_md_busy  = (md_left > 0);
      if (cur.md_op && (x_md_busy || x_md_start)) x_stall = 1'b1;
      x_fwd_rs_d = model_fwd_d(cur.body.rs);
      x_fwd_rt_d = model_fwd_d(cur.body.rt);
      x_fwd_rs_e = model_fwd_e(pipe[0].rs);
      x_fwd_rt_e = model_fwd_e(pipe[0].rt);
      x_fwd_rt_m = (pipe[1].rt != 0) && (pipe[2].dst == pipe[1].rt);
   endtask

   task automatic model_step();
      int started;
      started = pipe[0].md;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = x_stall ? empty_inst() : cur.body;
      if (started == 1)      md_left = int'(MUL_CYC);
      else if (started == 2) md_left = int'(DIV_CYC);
      else if (md_left > 0)  md_left = md_left - 1;
   endtask

   // ---------------- drivers (called at negedge) ----------------
   task automatic apply(input logic [31:0] ins);
      instr_d = ins;
      #1;
      model_eval();
   endtask

   task automatic advance();
      @(posedge clk);
      model_step();
      @(negedge clk);
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset   = 1'b0;
      instr_d = 32'h0;
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   function automatic logic [4:0] pick_reg();
      case ($urandom_range(0, 4))
         0:       return 5'd0;
         1:       return 5'd1;
         2:       return 5'd2;
         3:       return 5'd3;
         default: return 5'd31;
      endcase
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [4:0] a, b, c;
      a = pick_reg(); b = pick_reg(); c = pick_reg();
      case ($urandom_range(0, 15))
         0:  return r_type(a, b, c, 6'h21);
         1:  return r_type(a, b, c, 6'h23);
         2:  return r_type(5'd0, b, c, 6'h00) | 32'h0000_0080;
         3:  return r_type(a, 5'd0, 5'd0, 6'h08);
         4:  return r_type(a, 5'd0, c, 6'h09);
         5:  return i_type(6'h0d, a, b, 16'h0005);
         6:  return i_type(6'h0f, 5'd0, b, 16'h1234);
         7:  return i_type(6'h23, a, b, 16'h0004);
         8:  return i_type(6'h2b, a, b, 16'h0008);
         9:  return i_type(6'h04, a, b, 16'h0003);
         10: return {6'h03, 26'h0000100};
         11: return {6'h02, 26'h0000200};
         12: return r_type(a, b, 5'd0, 6'h18);
         13: return r_type(a, b, 5'd0, ($urandom_range(0, 1) == 0) ? 6'h1a : 6'h18);
         14: return r_type(5'd0, 5'd0, c, ($urandom_range(0, 1) == 0) ? 6'h10 : 6'h12);
         default: return $urandom;
      endcase
   endfunction

   // ---------------- tests ----------------
   task automatic test_reset();
      @(negedge clk);
      reset   = 1'b0;
      instr_d = 32'h0;
      #2;
      total++;
      if ({stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy, md_start} !== 12'h000) begin
         bad++;
         $display("FAIL reset_outputs: got %03h want 000",
                  {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy, md_start});
      end
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_load_use();
      do_reset();
      apply(i_type(6'h23, 5'd0, 5'd1, 16'h0));
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL load_use_lw_in_d: stall got %0b want 0", stall); end
      advance();
      apply(r_type(5'd1, 5'd3, 5'd2, 6'h21));
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL load_use_stall1: stall got %0b want 1", stall); end
      advance();
      apply(r_type(5'd1, 5'd3, 5'd2, 6'h21));
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL load_use_release: stall got %0b want 0", stall); end
      advance();
      apply(32'h0);
      total++; if (fwd_rs_e !== 2'd2) begin bad++; $display("FAIL load_use_fwd_rs_e: got %0d want 2", fwd_rs_e); end
   endtask

   task automatic test_load_branch();
      do_reset();
      apply(i_type(6'h23, 5'd0, 5'd1, 16'h0));
      advance();
      for (int i = 0; i < 2; i++) begin
         apply(i_type(6'h04, 5'd1, 5'd2, 16'h4));
         total++; if (stall !== 1'b1) begin bad++; $display("FAIL load_branch_stall%0d: got %0b want 1", i, stall); end
         advance();
      end
      apply(i_type(6'h04, 5'd1, 5'd2, 16'h4));
      total++;
      if ({stall, fwd_rs_d} !== 3'b000) begin
         bad++; $display("FAIL load_branch_release: stall/fwd_rs_d got %0b/%0d want 0/0", stall, fwd_rs_d);
      end
   endtask

   task automatic test_alu_branch();
      do_reset();
      apply(i_type(6'h0d, 5'd0, 5'd4, 16'h5));
      advance();
      apply(i_type(6'h04, 5'd4, 5'd0, 16'h2));
      total++; if (stall !== 1'b1) begin bad++; $display("FAIL alu_branch_stall: got %0b want 1", stall); end
      advance();
      apply(i_type(6'h04, 5'd4, 5'd0, 16'h2));
      total++;
      if ({stall, fwd_rs_d, fwd_rt_d} !== 5'b0_10_00) begin
         bad++; $display("FAIL alu_branch_fwd: stall/rs_d/rt_d got %0b/%0d/%0d want 0/2/0", stall, fwd_rs_d, fwd_rt_d);
      end
   endtask

   task automatic test_jal_jr();
      do_reset();
      apply({6'h03, 26'h0000040});
      advance();
      apply(r_type(5'd31, 5'd0, 5'd0, 6'h08));
      total++;
      if ({stall, fwd_rs_d} !== 3'b0_01) begin
         bad++; $display("FAIL jal_jr_fwd: stall/fwd_rs_d got %0b/%0d want 0/1", stall, fwd_rs_d);
      end
   endtask

   task automatic test_sw_data();
      do_reset();
      apply(i_type(6'h23, 5'd0, 5'd1, 16'h0));
      advance();
      apply(i_type(6'h2b, 5'd2, 5'd1, 16'h8));
      total++; if (stall !== 1'b0) begin bad++; $display("FAIL sw_no_stall: got %0b want 0", stall); end
      advance();
      apply(32'h0);
      total++; if (fwd_rt_e !== 2'd0) begin bad++; $display("FAIL sw_fwd_rt_e: got %0d want 0", fwd_rt_e); end
      advance();
      apply(32'h0);
      total++; if (fwd_rt_m !== 1'b1) begin bad++; $display("FAIL sw_fwd_rt_m: got %0b want 1", fwd_rt_m); end
   endtask

   task automatic test_div_mflo();
      int  n_stall, n_busy, n_start;
      bit  prev_busy, done;
      do_reset();
      apply(r_type(5'd1, 5'd2, 5'd0, 6'h1a));
      total++; if ({stall, md_start} !== 2'b00) begin bad++; $display("FAIL div_in_d: stall/md_start got %0b/%0b want 0/0", stall, md_start); end
      advance();
      n_stall = 0; n_busy = 0; n_start = 0; prev_busy = 1'b0; done = 1'b0;
      for (int i = 0; i < 40 && !done; i++) begin
         apply(r_type(5'd0, 5'd0, 5'd4, 6'h12));
         if (stall === 1'b1) n_stall++;
         if (md_busy === 1'b1) n_busy++;
         if (md_start === 1'b1) n_start++;
         if (stall === 1'b0) begin
            done = 1'b1;
            total++;
            if ({md_busy, prev_busy} !== 2'b01) begin
               bad++; $display("FAIL div_mflo_release_edge: busy/prev got %0b/%0b want 0/1", md_busy, prev_busy);
            end
         end
         prev_busy = md_busy;
         advance();
      end
      total++;
      if (!done) begin bad++; $display("FAIL div_mflo_timeout: stall never released in 40 cycles"); end
      total++;
      if (n_stall != 11 || n_busy != 10 || n_start != 1) begin
         bad++; $display("FAIL div_mflo_counts: stall/busy/start got %0d/%0d/%0d want 11/10/1", n_stall, n_busy, n_start);
      end
   endtask

   task automatic test_zero_reg();
      do_reset();
      apply(i_type(6'h23, 5'd0, 5'd0, 16'h0));
      advance();
      apply(r_type(5'd0, 5'd0, 5'd5, 6'h21));
      total++;
      if ({stall, fwd_rs_d, fwd_rt_d} !== 5'b0) begin
         bad++; $display("FAIL zero_reg_d: stall/rs_d/rt_d got %0b/%0d/%0d want 0/0/0", stall, fwd_rs_d, fwd_rt_d);
      end
      advance();
      apply(32'h0);
      total++;
      if ({fwd_rs_e, fwd_rt_e, fwd_rt_m} !== 5'b0) begin
         bad++; $display("FAIL zero_reg_e: rs_e/rt_e/rt_m got %0d/%0d/%0b want 0/0/0", fwd_rs_e, fwd_rt_e, fwd_rt_m);
      end
   endtask

   task automatic test_reset_mid_div();
      do_reset();
      apply(r_type(5'd1, 5'd2, 5'd0, 6'h1a));
      advance();
      apply(32'h0);
      total++; if (md_start !== 1'b1) begin bad++; $display("FAIL mid_div_start: got %0b want 1", md_start); end
      advance();
      apply(32'h0);
      advance();
      apply(32'h0);
      total++; if (md_busy !== 1'b1) begin bad++; $display("FAIL mid_div_busy: got %0b want 1", md_busy); end
      #2;
      reset = 1'b0;
      #1;
      total++;
      if ({md_busy, md_start, stall} !== 3'b000) begin
         bad++; $display("FAIL mid_div_async_reset: busy/start/stall got %0b/%0b/%0b want 0/0/0", md_busy, md_start, stall);
      end
      model_reset();
      @(negedge clk);
      reset = 1'b1;
   endtask

   task automatic test_random();
      logic [31:0] ins;
      logic [11:0] obs, expv;
      do_reset();
      ins = rand_instr();
      for (int i = 0; i < 400; i++) begin
         apply(ins);
         obs  = {stall, fwd_rs_d, fwd_rt_d, fwd_rs_e, fwd_rt_e, fwd_rt_m, md_busy, md_start};
         expv = {x_stall, 2'(x_fwd_rs_d), 2'(x_fwd_rt_d), 2'(x_fwd_rs_e), 2'(x_fwd_rt_e),
                 x_fwd_rt_m, x_md_busy, x_md_start};
         total++;
         if (obs !== expv) begin
            bad++;
            $display("FAIL random_cycle%0d instr=%08h: {stall,rs_d,rt_d,rs_e,rt_e,rt_m,busy,start} got %03h want %03h",
                     i, ins, obs, expv);
         end
         advance();
         if (!x_stall) ins = rand_instr();
      end
   endtask

   initial begin
      reset   = 1'b1;
      instr_d = 32'h0;
      model_reset();
      test_reset();
      test_load_use();
      test_load_branch();
      test_alu_branch();
      test_jal_jr();
      test_sw_data();
      test_div_mflo();
      test_zero_reg();
      test_reset_mid_div();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1);
   end

endmodule
